// File: rtl/mult9x9_share_arb.sv
// rtl/mult9x9_share_arb.sv - round-robin arbiter sharing one 9x9 multiplier among NREQ requesters
// Optional output register stage enabled by defining MULT9X9_SHARE_OUTREG_EN.
module mult9x9_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [9*NREQ-1:0] REQ_A,
    input  logic [9*NREQ-1:0] REQ_B,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [IDW-1:0]    RES_ID,
    output logic [17:0]       RES_Z,
    output logic              BUSY
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           adv;
    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic           xfer;

    logic [8:0]     a_q, b_q;
    logic [IDW-1:0] id1_q;
    logic           v1_q;
    logic [17:0]    prod;

    // Scan from the farthest offset down so the nearest valid requester to ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (REQ_VALID[(int'(ptr_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign adv  = !RES_VALID || RES_READY;
    assign xfer = gnt_found && adv && !RST;

    always_comb begin
        REQ_READY = '0;
        if (xfer) begin
            REQ_READY[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

    // All stage registers share RST and adv so they can fold into the DSP registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            id1_q <= '0;
            v1_q  <= 1'b0;
        end else if (adv) begin
            ptr_q <= ptr_d;
            v1_q  <= gnt_found;
            if (gnt_found) begin
                a_q   <= REQ_A[9*gnt_id +: 9];
                b_q   <= REQ_B[9*gnt_id +: 9];
                id1_q <= gnt_id;
            end
        end
    end

    assign prod = 18'(a_q) * 18'(b_q);

`ifdef MULT9X9_SHARE_OUTREG_EN
    logic [17:0]    z_q;
    logic [IDW-1:0] id2_q;
    logic           v2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            z_q   <= '0;
            id2_q <= '0;
            v2_q  <= 1'b0;
        end else if (adv) begin
            z_q   <= prod;
            id2_q <= id1_q;
            v2_q  <= v1_q;
        end
    end

    assign RES_VALID = v2_q;
    assign RES_ID    = id2_q;
    assign RES_Z     = z_q;
    assign BUSY      = v1_q || v2_q;
`else
    assign RES_VALID = v1_q;
    assign RES_ID    = id1_q;
    assign RES_Z     = prod;
    assign BUSY      = v1_q;
`endif

endmodule

// File: tb/tb_mult9x9_share_arb.sv
// tb/tb_mult9x9_share_arb.sv - self-checking bench for mult9x9_share_arb
module tb_mult9x9_share_arb;

    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef MULT9X9_SHARE_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [8:0]     op_a [N];
    logic [8:0]     op_b [N];
    logic [9*N-1:0] req_a, req_b;
    logic           res_valid, res_ready, busy;
    logic [IDW-1:0] res_id;
    logic [17:0]    res_z;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[9*i +: 9] = op_a[i];
            req_b[9*i +: 9] = op_b[i];
        end
    end

    mult9x9_share_arb #(.NREQ(N)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_A(req_a), .REQ_B(req_b),
        .RES_VALID(res_valid), .RES_READY(res_ready),
        .RES_ID(res_id), .RES_Z(res_z), .BUSY(busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pipeline as a small array of (valid, id, product) slots.
    int  m_ptr;
    bit  m_v  [2];
    int  m_id [2];
    int  m_z  [2];
    bit  armed = 0;
    int  acc_last = -1;

    typedef struct { int id; int z; } exp_t;
    exp_t dq[$];

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit m_adv();
        return !m_v[LAT-1] || res_ready;
    endfunction

    task automatic check_model();
        int g;
        logic [N-1:0] er;
        g  = m_grant();
        er = '0;
        if (!rst && g >= 0 && m_adv()) er[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("res_valid", 32'(res_valid), 32'(m_v[LAT-1]));
        if (m_v[LAT-1]) begin
            chk("res_id", 32'(res_id), 32'(m_id[LAT-1]));
            chk("res_z", 32'(res_z), 32'(m_z[LAT-1]));
        end
        chk("busy", 32'(busy), 32'(m_v[0] || m_v[LAT-1]));
    endtask

    task automatic model_update();
        int g;
        bit a;
        g = m_grant();
        a = m_adv();
        acc_last = -1;
        if (rst) begin
            m_ptr = 0;
            for (int s = 0; s < 2; s++) begin
                m_v[s] = 0; m_id[s] = 0; m_z[s] = 0;
            end
        end else if (a) begin
            if (LAT == 2) begin
                m_v[1] = m_v[0]; m_id[1] = m_id[0]; m_z[1] = m_z[0];
            end
            m_v[0] = (g >= 0);
            if (g >= 0) begin
                m_id[0]  = g;
                m_z[0]   = int'(op_a[g]) * int'(op_b[g]);
                m_ptr    = (g + 1) % N;
                acc_last = g;
            end
        end
    endtask

    // Called #1 after inputs change on the falling edge; ends on the next falling edge.
    task automatic cycle();
        if (armed) check_model();
        if (res_valid && res_ready && dq.size() > 0) begin
            exp_t e;
            e = dq.pop_front();
            chk("dir_id", 32'(res_id), 32'(e.id));
            chk("dir_z", 32'(res_z), 32'(e.z));
        end
        @(posedge clk);
        model_update();
        armed = 1;
        @(negedge clk);
    endtask

    task automatic set_all_ops(input logic [8:0] a, input logic [8:0] b);
        for (int i = 0; i < N; i++) begin
            op_a[i] = a;
            op_b[i] = b;
        end
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [8:0]  a;
        logic [8:0]  b;
        logic        rr;
        logic [3:0]  rdy;
        logic [1:0]  id;
        logic [17:0] z;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{4'b1111, 9'd1,    9'd2,    1'b1, 4'b0001, 2'd0, 18'd2};
        tbl[1]  = '{4'b1111, 9'd3,    9'd4,    1'b1, 4'b0010, 2'd1, 18'd12};
        tbl[2]  = '{4'b1111, 9'd5,    9'd6,    1'b1, 4'b0100, 2'd2, 18'd30};
        tbl[3]  = '{4'b1111, 9'd7,    9'd8,    1'b1, 4'b1000, 2'd3, 18'd56};
        tbl[4]  = '{4'b1111, 9'd9,    9'd10,   1'b1, 4'b0001, 2'd0, 18'd90};
        tbl[5]  = '{4'b1111, 9'd11,   9'd12,   1'b1, 4'b0010, 2'd1, 18'd132};
        tbl[6]  = '{4'b0000, 9'd0,    9'd0,    1'b1, 4'b0000, 2'd0, 18'd0};
        tbl[7]  = '{4'b0000, 9'd0,    9'd0,    1'b1, 4'b0000, 2'd0, 18'd0};
        tbl[8]  = '{4'b1010, 9'd5,    9'd7,    1'b1, 4'b1000, 2'd3, 18'd35};
        tbl[9]  = '{4'b1010, 9'd5,    9'd7,    1'b1, 4'b0010, 2'd1, 18'd35};
        tbl[10] = '{4'b1010, 9'd5,    9'd7,    1'b1, 4'b1000, 2'd3, 18'd35};
        tbl[11] = '{4'b0100, 9'h1FF,  9'h1FF,  1'b1, 4'b0100, 2'd2, 18'h3FC01};
        tbl[12] = '{4'b0000, 9'd0,    9'd0,    1'b1, 4'b0000, 2'd0, 18'd0};
        tbl[13] = '{4'b0000, 9'd0,    9'd0,    1'b1, 4'b0000, 2'd0, 18'd0};

        rst = 1'b1; req_valid = '1; res_ready = 1'b0;
        set_all_ops(9'd0, 9'd0);
        @(negedge clk);

        // Reset held with every requester asserting valid.
        #1; cycle();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_res_z", 32'(res_z), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            cycle();
        end
        rst = 1'b0;

        // Rotation, pointer skip and full-scale single op.
        for (int r = 0; r < 14; r++) begin
            req_valid = tbl[r].v;
            set_all_ops(tbl[r].a, tbl[r].b);
            res_ready = tbl[r].rr;
            if (tbl[r].rdy != 4'b0000) dq.push_back('{int'(tbl[r].id), int'(tbl[r].z)});
            #1;
            chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].rdy));
            cycle();
        end
        chk("dir_left", 32'(dq.size()), 32'd0);
        dq.delete();

        // Backpressure with results in flight, then drain.
        for (int i = 0; i < N; i++) begin
            op_a[i] = 9'(20 + i);
            op_b[i] = 9'(3 + i);
        end
        req_valid = '1;
        res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin #1; cycle(); end
        res_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_valid", 32'(res_valid), 32'd1);
            cycle();
        end
        res_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin #1; cycle(); end
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin #1; cycle(); end

        // Reset one cycle after accepting an op.
        req_valid = 4'b0001;
        op_a[0] = 9'd3; op_b[0] = 9'd4;
        #1;
        chk("mid_accept", 32'(req_ready), 32'b0001);
        cycle();
        req_valid = '0;
        rst = 1'b1;
        #1; cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("mid_res_valid", 32'(res_valid), 32'd0);
            chk("mid_busy", 32'(busy), 32'd0);
            cycle();
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc_last == i || $urandom_range(0, 15) == 0) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    op_a[i] = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom);
                    op_b[i] = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom);
                end
            end
            #1; cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
